// File: rtl/borrow_look_ahead_divider_eight.sv
// Sequential 8-bit unsigned restoring divider, one quotient bit per clock.
// Each iteration does one trial subtraction through a 9-bit borrow look-ahead
// subtractor whose borrows are flat sum-of-products terms with no ripple chain.
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start             request; accepted only in IDLE or DONE
//   dividend, divisor unsigned operands, sampled with an accepted start
//   busy              high while iterating
//   done              one-cycle pulse when results become valid
//   div_by_zero       latched divisor was zero; held until the next accept
//   quotient          result, held until the next result is produced
//   remainder         result, held until the next result is produced
module borrow_look_ahead_divider_eight #(
  parameter logic [7:0] DZ_QUOTIENT = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [7:0] divisor,
  output logic       busy,
  output logic       done,
  output logic       div_by_zero,
  output logic [7:0] quotient,
  output logic [7:0] remainder
);

  localparam int unsigned W  = 8;
  localparam int unsigned SW = W + 1;
  localparam int unsigned CW = 3;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  q, q_nxt;
  logic [W-1:0]  r, r_nxt;
  logic [W-1:0]  dvsr, dvsr_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [W-1:0]  quo_nxt, rem_nxt;
  logic          dbz_nxt;

  // Borrow into bit i: OR over j<i of g[j] AND p[j+1..i-1], borrow-in zero.
  function automatic logic borrow_at(input logic [SW-1:0] g,
                                     input logic [SW-1:0] p,
                                     input int unsigned   i);
    logic acc;
    logic term;
    acc = 1'b0;
    for (int unsigned j = 0; j < SW; j++) begin
      if (j < i) begin
        term = g[j];
        for (int unsigned k = 0; k < SW; k++) begin
          if (k > j && k < i) term = term & p[k];
        end
        acc = acc | term;
      end
    end
    return acc;
  endfunction

  // Trial subtraction S - {0,divisor}, S = {R, next dividend bit}.
  logic [SW-1:0] s_ext, d_ext, g, p;
  logic [W-1:0]  dif;
  logic          bout;

  assign s_ext = {r, q[W-1]};
  assign d_ext = {1'b0, dvsr};

  always_comb begin
    g = ~s_ext & d_ext;
    p = ~(s_ext ^ d_ext);
    for (int unsigned i = 0; i < W; i++) begin
      dif[i] = ~p[i] ^ borrow_at(g, p, i);
    end
    bout = borrow_at(g, p, SW);
  end

  // The kept remainder is always below the divisor, so bit 8 is zero either way.
  logic [W-1:0] r_step, q_step;
  assign r_step = bout ? s_ext[W-1:0] : dif;
  assign q_step = {q[W-2:0], ~bout};

  logic accept;
  assign accept = start && (state != RUN);

  // Next-state and next-value logic.
  always_comb begin
    state_nxt = state;
    q_nxt     = q;
    r_nxt     = r;
    dvsr_nxt  = dvsr;
    cnt_nxt   = cnt;
    quo_nxt   = quotient;
    rem_nxt   = remainder;
    dbz_nxt   = div_by_zero;
    case (state)
      IDLE, DONE: begin
        state_nxt = IDLE;
        if (accept) begin
          if (divisor == '0) begin
            quo_nxt   = DZ_QUOTIENT;
            rem_nxt   = dividend;
            dbz_nxt   = 1'b1;
            state_nxt = DONE;
          end else begin
            dvsr_nxt  = divisor;
            q_nxt     = dividend;
            r_nxt     = '0;
            cnt_nxt   = '0;
            dbz_nxt   = 1'b0;
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        q_nxt   = q_step;
        r_nxt   = r_step;
        cnt_nxt = cnt + CW'(1);
        if (cnt == CW'(W - 1)) begin
          quo_nxt   = q_step;
          rem_nxt   = r_step;
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      q           <= '0;
      r           <= '0;
      dvsr        <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
    end else begin
      state       <= state_nxt;
      q           <= q_nxt;
      r           <= r_nxt;
      dvsr        <= dvsr_nxt;
      cnt         <= cnt_nxt;
      busy        <= (state_nxt == RUN);
      done        <= (state_nxt == DONE);
      div_by_zero <= dbz_nxt;
      quotient    <= quo_nxt;
      remainder   <= rem_nxt;
    end
  end

endmodule

// File: tb/tb_borrow_look_ahead_divider_eight.sv
module tb_borrow_look_ahead_divider_eight;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic       div_by_zero;
  logic [7:0] quotient;
  logic [7:0] remainder;

  borrow_look_ahead_divider_eight dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .quotient(quotient), .remainder(remainder)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
  } exp_t;

  exp_t sbq[$];
  exp_t me;
  int   cmp_cnt = 0;
  int   err_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer division, divide-by-zero convention.
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    e.a = a;
    e.b = b;
    if (b == 8'd0) begin
      e.q = 8'hFF;
      e.r = a;
      e.z = 1'b1;
    end else begin
      e.q = 8'(int'(a) / int'(b));
      e.r = 8'(int'(a) % int'(b));
      e.z = 1'b0;
    end
    return e;
  endfunction

  // Monitor: every done pulse consumes one expected result.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sbq.size() == 0) begin
        cmp_cnt++;
        err_cnt++;
        $display("FAIL unexpected_done: got done=1, expected no pending result (t=%0t)", $time);
      end else begin
        me = sbq.pop_front();
        check($sformatf("quotient %0d/%0d", me.a, me.b), 32'(quotient), 32'(me.q));
        check($sformatf("remainder %0d/%0d", me.a, me.b), 32'(remainder), 32'(me.r));
        check($sformatf("div_by_zero %0d/%0d", me.a, me.b), 32'(div_by_zero), 32'(me.z));
        check("busy_with_done", 32'(busy), 32'd0);
        if (me.b != 8'd0) begin
          check("invariant_sum", 32'(quotient) * 32'(me.b) + 32'(remainder), 32'(me.a));
          check("invariant_rem_lt_div", 32'(remainder < me.b), 32'd1);
        end
      end
    end
  end

  // One operation from idle: checks latency, busy length, stability and pulse width.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b);
    int n;
    int busy_n;
    logic [7:0] pq;
    logic [7:0] pr;
    @(negedge clk);
    pq = quotient;
    pr = remainder;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    sbq.push_back(model(a, b));
    @(negedge clk);
    start  = 1'b0;
    n      = 0;
    busy_n = 0;
    while (!done && n < 20) begin
      if (busy) busy_n++;
      if (n == 4) begin
        check("quotient_stable_run", 32'(quotient), 32'(pq));
        check("remainder_stable_run", 32'(remainder), 32'(pr));
      end
      @(negedge clk);
      n++;
    end
    check($sformatf("latency %0d/%0d", a, b), n, (b == 8'd0) ? 32'd0 : 32'd8);
    check($sformatf("busy_cycles %0d/%0d", a, b), busy_n, (b == 8'd0) ? 32'd0 : 32'd8);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_dbz", 32'(div_by_zero), 32'd0);
    check("reset_quotient", 32'(quotient), 32'd0);
    check("reset_remainder", 32'(remainder), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);

    // Directed cases.
    run_op(8'd200, 8'd7);
    run_op(8'd255, 8'd1);
    run_op(8'd5, 8'd9);
    run_op(8'd255, 8'd255);
    run_op(8'h5A, 8'd0);
    check("dbz_held_in_idle", 32'(div_by_zero), 32'd1);
    run_op(8'd10, 8'd3);
    check("dbz_cleared", 32'(div_by_zero), 32'd0);

    // Start during RUN must be ignored.
    @(negedge clk);
    dividend = 8'd100;
    divisor  = 8'd10;
    start    = 1'b1;
    sbq.push_back(model(8'd100, 8'd10));
    @(negedge clk);
    start = 1'b0;
    n = 0;
    repeat (3) begin @(negedge clk); n++; end
    dividend = 8'd9;
    divisor  = 8'd2;
    start    = 1'b1;
    @(negedge clk);
    n++;
    start = 1'b0;
    while (!done && n < 20) begin @(negedge clk); n++; end
    check("ignored_start_latency", n, 32'd8);
    repeat (12) @(negedge clk);

    // Back-to-back with start held high.
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    sbq.push_back(model(8'd100, 8'd7));
    n = 0;
    while (!done && n < 20) begin @(negedge clk); n++; end
    dividend = 8'd50;
    divisor  = 8'd6;
    sbq.push_back(model(8'd50, 8'd6));
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 20) begin @(negedge clk); n++; end
    check("back_to_back_gap", n, 32'd9);
    repeat (3) @(negedge clk);

    // Reset in the middle of an iteration.
    dividend = 8'd200;
    divisor  = 8'd3;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrun_rst_busy", 32'(busy), 32'd0);
    check("midrun_rst_done", 32'(done), 32'd0);
    check("midrun_rst_quotient", 32'(quotient), 32'd0);
    check("midrun_rst_remainder", 32'(remainder), 32'd0);
    check("midrun_rst_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    run_op(8'd77, 8'd8);

    // Random operands, occasional zero divisor.
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] a;
      logic [7:0] b;
      a = 8'($urandom_range(0, 255));
      b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      run_op(a, b);
    end

    repeat (4) @(negedge clk);
    check("scoreboard_empty", sbq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
